// File: rtl/ippcrc_pkg.sv
// Shared CRC-32 definitions: FSM encoding, polynomial constants and a
// reflected (LSB-first) byte step used by both combinational cores.
package ippcrc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_TAIL = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [31:0] CRC32_POLY       = 32'h04C11DB7;
  // Bit-reversed CRC32_POLY; the register is kept in reflected order.
  localparam logic [31:0] CRC32_POLY_REFL  = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT_DEF   = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_XOROUT_DEF = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE    = 32'hC704DD7B;

  function automatic logic [31:0] crc32_byte(input logic [31:0] ci,
                                             input logic [7:0]  d);
    logic [31:0] c;
    c = ci ^ {24'h0, d};
    for (int i = 0; i < 8; i++)
      c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
    return c;
  endfunction

endpackage

// File: rtl/ippcrc_crc32_8b.sv
// Combinational CRC-32 over a single byte, same bit order as the 96-bit core.
module ippcrc_crc32_8b
  import ippcrc_pkg::*;
(
  input  logic [31:0] ci,
  input  logic [7:0]  di,
  output logic [31:0] co
);

  always_comb co = crc32_byte(ci, di);

endmodule

// File: rtl/ippcrc_crc32_96b.sv
// Combinational CRC-32 over a 12-byte word; byte 0 sits in di[95:88].
module ippcrc_crc32_96b
  import ippcrc_pkg::*;
(
  input  logic [31:0] ci,
  input  logic [95:0] di,
  output logic [31:0] co
);

  always_comb begin
    co = ci;
    for (int k = 0; k < 12; k++)
      co = crc32_byte(co, di[95-8*k -: 8]);
  end

endmodule

// File: rtl/ippcrc_crc32_frm96.sv
// Framed CRC-32 over 96-bit words: full words go through the 96-bit core in
// one cycle, a partial last word is folded one byte per cycle in TAIL.
module ippcrc_crc32_frm96
  import ippcrc_pkg::*;
#(
  parameter logic [31:0] CRC_INIT   = CRC32_INIT_DEF,
  parameter logic [31:0] CRC_XOROUT = CRC32_XOROUT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        di_vld,
  output logic        di_rdy,
  input  logic        di_sop,
  input  logic        di_eop,
  input  logic [3:0]  di_nbyte,
  input  logic [95:0] di,
  output logic        crc_vld,
  output logic [31:0] crc,
  output logic        crc_err
);

  state_e      state_q, state_d;
  logic [31:0] crc_q, crc_d;
  logic [95:0] tail_q, tail_d;
  logic [3:0]  tcnt_q, tcnt_d;
  logic [31:0] crco_q, crco_d;
  logic        vld_q, vld_d;
  logic        err_q, err_d;
  logic        rdy_en_q;

  logic        xfer, nb_big, nb_full;
  logic [31:0] core_ci, c96, c8;

  // Held low through reset and for the cycle of release.
  assign di_rdy  = rdy_en_q & ((state_q == ST_IDLE) | (state_q == ST_RUN));
  assign xfer    = di_vld & di_rdy;
  assign nb_big  = di_nbyte > 4'd12;
  assign nb_full = (di_nbyte == 4'd0) | (di_nbyte >= 4'd12);
  assign core_ci = ((state_q == ST_IDLE) | di_sop) ? CRC_INIT : crc_q;

  assign crc_vld = vld_q;
  assign crc     = crco_q;
  assign crc_err = err_q;

  ippcrc_crc32_96b u_core96 (
    .ci (core_ci),
    .di (di),
    .co (c96)
  );

  ippcrc_crc32_8b u_core8 (
    .ci (crc_q),
    .di (tail_q[95:88]),
    .co (c8)
  );

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    tail_d  = tail_q;
    tcnt_d  = tcnt_q;
    crco_d  = crco_q;
    vld_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE, ST_RUN: begin
        if (xfer) begin
          if ((state_q == ST_IDLE) && !di_sop) begin
            err_d = 1'b1;
          end else begin
            // A sop while already in a frame aborts it and restarts here.
            err_d = (state_q == ST_RUN) && di_sop;
            if (!di_eop) begin
              crc_d   = c96;
              state_d = ST_RUN;
            end else if (nb_full) begin
              err_d   = err_d | nb_big;
              crc_d   = c96;
              crco_d  = c96 ^ CRC_XOROUT;
              vld_d   = 1'b1;
              state_d = ST_DONE;
            end else begin
              crc_d   = core_ci;
              tail_d  = di;
              tcnt_d  = di_nbyte;
              state_d = ST_TAIL;
            end
          end
        end
      end
      ST_TAIL: begin
        crc_d  = c8;
        tail_d = {tail_q[87:0], 8'h00};
        tcnt_d = tcnt_q - 4'd1;
        if (tcnt_q == 4'd1) begin
          crco_d  = c8 ^ CRC_XOROUT;
          vld_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        crc_d   = CRC_INIT;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      crc_q    <= CRC_INIT;
      tail_q   <= '0;
      tcnt_q   <= '0;
      crco_q   <= '0;
      vld_q    <= 1'b0;
      err_q    <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      crc_q    <= crc_d;
      tail_q   <= tail_d;
      tcnt_q   <= tcnt_d;
      crco_q   <= crco_d;
      vld_q    <= vld_d;
      err_q    <= err_d;
      rdy_en_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ippcrc_crc32_frm96.sv
// Self-checking bench: random and directed frames against a table-driven
// byte-stream CRC-32 model.
module tb_ippcrc_crc32_frm96;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        di_vld = 1'b0, di_sop = 1'b0, di_eop = 1'b0;
  logic [3:0]  di_nbyte = '0;
  logic [95:0] di = '0;
  logic        di_rdy, crc_vld, crc_err;
  logic [31:0] crc;

  ippcrc_crc32_frm96 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .di_vld   (di_vld),
    .di_rdy   (di_rdy),
    .di_sop   (di_sop),
    .di_eop   (di_eop),
    .di_nbyte (di_nbyte),
    .di       (di),
    .crc_vld  (crc_vld),
    .crc      (crc),
    .crc_err  (crc_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int nvec = 0, nerr = 0;
  int err_cnt = 0, vld_cnt = 0;
  int xfer_cyc = 0, tot_st = 0;
  logic [31:0] last_crc;
  logic [31:0] tbl [256];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (crc_err) err_cnt <= err_cnt + 1;
    if (crc_vld) vld_cnt <= vld_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_crc(input logic [7:0] q[$]);
    logic [31:0] c = 32'hFFFFFFFF;
    foreach (q[i]) c = tbl[(c ^ {24'h0, q[i]}) & 32'hFF] ^ (c >> 8);
    return c ^ 32'hFFFFFFFF;
  endfunction

  task automatic send_word(input logic sop, input logic eop, input logic [3:0] nb,
                           input logic [95:0] data);
    int st = 0;
    di_vld = 1'b1; di_sop = sop; di_eop = eop; di_nbyte = nb; di = data;
    while (!di_rdy && st < 50) begin
      @(negedge clk);
      st++;
    end
    tot_st += st;
    @(posedge clk);
    #1 xfer_cyc = cyc;
    @(negedge clk);
  endtask

  task automatic idle();
    di_vld = 1'b0; di_sop = 1'b0; di_eop = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] q[$], input bit nb0, input bit nb15,
                           input string tag);
    int n, nw, rem, lat;
    bit ok;
    logic [95:0] data;
    logic [3:0] nb;
    n = q.size();
    nw = (n + 11) / 12;
    rem = n - (nw - 1) * 12;
    for (int w = 0; w < nw; w++) begin
      for (int k = 0; k < 12; k++)
        data[95-8*k -: 8] = (w*12 + k < n) ? q[w*12 + k] : 8'($urandom);
      if (w != nw - 1) nb = 4'($urandom);
      else if (rem == 12) nb = nb15 ? 4'd15 : (nb0 ? 4'd0 : 4'd12);
      else nb = 4'(rem);
      send_word(w == 0, w == nw - 1, nb, data);
    end
    idle();
    ok = 1'b0;
    lat = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (crc_vld) begin
        ok = 1'b1;
        lat = cyc - xfer_cyc + 1;
        last_crc = crc;
      end else begin
        @(negedge clk);
      end
    end
    chk({tag, "_vld"}, 32'(ok), 32'd1);
    chk({tag, "_lat"}, lat, (rem == 12) ? 32'd1 : 32'(rem + 1));
    chk({tag, "_crc"}, last_crc, ref_crc(q));
    @(negedge clk);
  endtask

  task automatic rand_bytes(input int n, output logic [7:0] q[$]);
    q = {};
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
  endtask

  initial begin
    logic [7:0] q[$];
    int e0, v0;
    for (int i = 0; i < 256; i++) begin
      logic [31:0] c;
      c = 32'(i);
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      tbl[i] = c;
    end

    // reset values and di_rdy release timing
    #1;
    chk("rst_rdy", 32'(di_rdy), 32'd0);
    chk("rst_vld", 32'(crc_vld), 32'd0);
    chk("rst_err", 32'(crc_err), 32'd0);
    chk("rst_crc", crc, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rel_rdy_low", 32'(di_rdy), 32'd0);
    @(posedge clk);
    #1 chk("rel_rdy_high", 32'(di_rdy), 32'd1);
    @(negedge clk);

    // check value "123456789" in a single word
    q = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    run_frame(q, 1'b0, 1'b0, "check");
    chk("check_const", last_crc, 32'hCBF43926);

    // 36 zero bytes, nbyte=0 on eop, no back-pressure
    q = {};
    for (int i = 0; i < 36; i++) q.push_back(8'h00);
    tot_st = 0;
    run_frame(q, 1'b1, 1'b0, "zero36");
    chk("zero36_stall", tot_st, 32'd0);

    // random frames
    for (int f = 0; f < 25; f++) begin
      rand_bytes($urandom_range(1, 60), q);
      run_frame(q, 1'($urandom), 1'b0, $sformatf("rnd%0d", f));
    end

    // sop in RUN aborts the first frame
    #1 e0 = err_cnt; v0 = vld_cnt;
    send_word(1'b1, 1'b0, 4'd0, {3{32'($urandom)}});
    send_word(1'b0, 1'b0, 4'd0, {3{32'($urandom)}});
    rand_bytes(30, q);
    run_frame(q, 1'b0, 1'b0, "abort");
    #1;
    chk("abort_err", err_cnt - e0, 32'd1);
    chk("abort_vld", vld_cnt - v0, 32'd1);

    // non-sop word in IDLE is dropped
    @(negedge clk);
    #1 e0 = err_cnt;
    send_word(1'b0, 1'b1, 4'd5, {3{32'($urandom)}});
    idle();
    #1 chk("nosop_rdy", 32'(di_rdy), 32'd1);
    @(negedge clk);
    #1 chk("nosop_err", err_cnt - e0, 32'd1);
    rand_bytes(17, q);
    run_frame(q, 1'b0, 1'b0, "nosop_next");

    // nbyte=15 is treated as 12 and flagged
    #1 e0 = err_cnt;
    rand_bytes(12, q);
    run_frame(q, 1'b0, 1'b1, "nb15");
    #1 chk("nb15_err", err_cnt - e0, 32'd1);

    // reset while folding the tail
    @(negedge clk);
    send_word(1'b1, 1'b1, 4'd11, {3{32'($urandom)}});
    idle();
    @(negedge clk);
    @(negedge clk);
    #1 v0 = vld_cnt;
    rst_n = 1'b0;
    #1;
    chk("tailrst_rdy", 32'(di_rdy), 32'd0);
    chk("tailrst_vld", 32'(crc_vld), 32'd0);
    chk("tailrst_crc", crc, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    #1 chk("tailrst_novld", vld_cnt - v0, 32'd0);
    rand_bytes(23, q);
    run_frame(q, 1'b0, 1'b0, "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/ippcrc_crc32_frm96.md
IPPCRC_CRC32_FRM96 -- requirements
Module: ippcrc_crc32_frm96

Interface
REQ-001 SHALL have parameter CRC_INIT, default 32'hFFFFFFFF, meaning the CRC register value loaded at the start of each frame.
REQ-002 SHALL have parameter CRC_XOROUT, default 32'hFFFFFFFF, meaning the value XORed onto the final CRC before output.
REQ-003 SHALL have port clk, input, 1, single clock; all logic is rising-edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port di_vld, input, 1, input word valid.
REQ-006 SHALL have port di_rdy, output, 1, block accepts the word this cycle.
REQ-007 SHALL have port di_sop, input, 1, first word of frame.
REQ-008 SHALL have port di_eop, input, 1, last word of frame.
REQ-009 SHALL have port di_nbyte, input, 4, valid bytes on the eop word (0 = 12).
REQ-010 SHALL have port di, input, 96, data word; byte k occupies di[95-8k:88-8k], with byte 0 first on the wire.
REQ-011 SHALL have port crc_vld, output, 1, one-cycle pulse when the frame CRC is available.
REQ-012 SHALL have port crc, output, 32, final CRC (register ^ CRC_XOROUT), held until the next crc_vld.
REQ-013 SHALL have port crc_err, output, 1, one-cycle pulse on a protocol error.

Function
REQ-014 A transfer SHALL occur when di_vld & di_rdy are both high in the same cycle.
REQ-015 The FSM SHALL have four states: IDLE, RUN, TAIL and DONE.
REQ-016 di_rdy SHALL be high in IDLE and RUN, and low in TAIL and DONE.
REQ-017 IDLE: transfers without di_sop SHALL be dropped and SHALL pulse crc_err.
REQ-018 IDLE: a sop transfer SHALL seed the 96-bit core with ci=CRC_INIT.
REQ-019 RUN: each non-eop transfer SHALL update the CRC register with ippcrc_crc32_96b(ci=reg, di) in the same cycle.
REQ-020 An eop transfer with di_nbyte of 0 or 12 SHALL update the register through the 96-bit core and go to DONE.
REQ-021 An eop transfer with di_nbyte of 1..11 SHALL latch the word and nbyte and go to TAIL.
REQ-022 TAIL SHALL fold one byte per cycle into the register via the 8-bit sub-module, in byte order 0..nbyte-1, then go to DONE.
REQ-023 TAIL SHALL take exactly nbyte cycles.
REQ-024 DONE SHALL last one cycle, drive crc = reg ^ CRC_XOROUT, pulse crc_vld, and return to IDLE.
REQ-025 Latency from the eop transfer to crc_vld SHALL be 1 cycle for full words and nbyte+1 cycles for partial words.
REQ-026 A word with both sop and eop SHALL be a valid single-word frame.
REQ-027 A sop received in RUN SHALL abort the current frame: pulse crc_err, produce no crc_vld, and restart the frame with CRC_INIT from that word.
REQ-028 di_nbyte > 12 SHALL pulse crc_err and be treated as 12.
REQ-029 crc_vld and crc_err MAY assert together only in the REQ-028 case.

Reset
REQ-030 While rst_n is low: state = IDLE, di_rdy = 0, crc_vld = 0, crc_err = 0, crc = 0, CRC register = CRC_INIT, tail counters = 0.
REQ-031 di_rdy SHALL rise the first clock after rst_n deasserts.
REQ-032 Reset mid-frame SHALL discard the frame with no crc_vld.

Structure
REQ-033 The shared package ippcrc_pkg SHALL hold the FSM state encoding, CRC32_POLY = 32'h04C11DB7, the default init/xorout values and the residue constant 32'hC704DD7B.
REQ-034 The design SHALL instantiate the existing 96-bit core and exactly one new combinational sub-module, ippcrc_crc32_8b (ci[31:0], di[7:0] -> co[31:0]), using the same bit convention as the 96-bit core.

Verification
REQ-035 A single word "123456789" plus 3 pad bytes, sop=eop=1, nbyte=9, with defaults -> crc = 32'hCBF43926, crc_vld 10 cycles after the transfer.
REQ-036 A 3-word frame of all-zero bytes, last word nbyte=0 (36 bytes) -> crc matches the software model, latency 1, di_rdy never drops.
REQ-037 sop, word, then sop again before eop -> one crc_err pulse, and only the second frame's CRC is reported.
REQ-038 A non-sop word in IDLE -> crc_err pulse and no state change; a following valid frame is computed correctly.
REQ-039 nbyte=15 on eop -> crc_err, and crc equals the 12-byte result.
REQ-040 rst_n low during TAIL -> outputs at reset values, no crc_vld, and the next frame is correct.
